// File: rtl/seg7_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
//   Shared constants for the multiplexed 7-segment scan decoder:
//   - SEG_0..SEG_F : active-low segment patterns {G,F,E,D,C,B,A} of the team
//                    7-segment encoder for nibbles 0x0..0xF
//   - SEG_BLANK    : all segments off
//   - AN_DIG0..3   : active-low anode codes selecting one digit
//   - digit_idx_t  : index of one of the four digits
// -----------------------------------------------------------------------------
package seg7_pkg;

    typedef logic [1:0] digit_idx_t;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b0000011;
    localparam logic [6:0] SEG_C     = 7'b1000110;
    localparam logic [6:0] SEG_D     = 7'b0100001;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_F     = 7'b0001110;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [3:0] AN_DIG0 = 4'hE;
    localparam logic [3:0] AN_DIG1 = 4'hD;
    localparam logic [3:0] AN_DIG2 = 4'hB;
    localparam logic [3:0] AN_DIG3 = 4'h7;
    localparam logic [3:0] AN_IDLE = 4'hF;

    // One-hot mask of a digit index, used for the frame "seen" mask.
    function automatic logic [3:0] digit_onehot(input digit_idx_t idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// -----------------------------------------------------------------------------
// seg7_decode
//   Purely combinational inverse of the team 7-segment encoder.
//   Ports:
//     seg    in  7  active-low segment pattern {G,F,E,D,C,B,A}
//     nibble out 4  decoded value (0 when blank or err)
//     blank  out 1  pattern is all segments off
//     err    out 1  pattern is neither a digit nor blank
// -----------------------------------------------------------------------------
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] nibble,
    output logic       blank,
    output logic       err
);

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves
        // one unassigned, which would otherwise infer a latch.
        nibble = 4'h0;
        blank  = 1'b0;
        err    = 1'b0;
        case (seg)
            SEG_0:     nibble = 4'h0;
            SEG_1:     nibble = 4'h1;
            SEG_2:     nibble = 4'h2;
            SEG_3:     nibble = 4'h3;
            SEG_4:     nibble = 4'h4;
            SEG_5:     nibble = 4'h5;
            SEG_6:     nibble = 4'h6;
            SEG_7:     nibble = 4'h7;
            SEG_8:     nibble = 4'h8;
            SEG_9:     nibble = 4'h9;
            SEG_A:     nibble = 4'hA;
            SEG_B:     nibble = 4'hB;
            SEG_C:     nibble = 4'hC;
            SEG_D:     nibble = 4'hD;
            SEG_E:     nibble = 4'hE;
            SEG_F:     nibble = 4'hF;
            SEG_BLANK: blank  = 1'b1;
            default:   err    = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg7_scan_decoder.sv
// -----------------------------------------------------------------------------
// seg7_scan_decoder
//   Watches the pins of a multiplexed 4-digit 7-segment display and recovers
//   the value shown on each digit. A digit is committed once its selection and
//   pattern have been sampled STABLE_CNT times in a row; all digit flags are
//   invalidated after TIMEOUT cycles without any commit.
//   Parameters:
//     STABLE_CNT  identical samples needed to commit (1..15)
//     TIMEOUT     cycles without commit before invalidation (16..65535)
//   Ports:
//     clk, rst_n          clock (rising edge), async active-low reset
//     Ai[3:0]             anode enables, active low, one bit per digit
//     Ci[6:0]             segment cathodes, active low, {G,F,E,D,C,B,A}
//     Di                  decimal point, active low
//     bcd0..bcd3[3:0]     last decoded value of each digit
//     dp[3:0]             decimal point per digit, active high
//     dig_valid[3:0]      digit holds a committed decodable value
//     dig_blank[3:0]      digit last committed with all segments off
//     dig_err[3:0]        digit last committed with an undecodable pattern
//     frame_done          one-cycle pulse once all four digits have committed
// -----------------------------------------------------------------------------
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int unsigned STABLE_CNT = 2,
    parameter int unsigned TIMEOUT    = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] Ai,
    input  logic [6:0] Ci,
    input  logic       Di,
    output logic [3:0] bcd0,
    output logic [3:0] bcd1,
    output logic [3:0] bcd2,
    output logic [3:0] bcd3,
    output logic [3:0] dp,
    output logic [3:0] dig_valid,
    output logic [3:0] dig_blank,
    output logic [3:0] dig_err,
    output logic       frame_done
);

    localparam logic [3:0]  STABLE_MAX   = 4'(STABLE_CNT);
    localparam logic [15:0] TIMEOUT_MAX  = 16'(TIMEOUT);
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

    // Input stage (q) and the previous sample (p) used for the stability test.
    logic [3:0] ai_q, ai_p;
    logic [6:0] ci_q, ci_p;
    logic       di_q, di_p;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ai_q <= AN_IDLE;
            ci_q <= SEG_BLANK;
            di_q <= 1'b1;
            ai_p <= AN_IDLE;
            ci_p <= SEG_BLANK;
            di_p <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments let ai_p take the old ai_q on the
            // same edge that ai_q takes the pin; blocking would collapse the
            // two stages into one.
            ai_q <= Ai;
            ci_q <= Ci;
            di_q <= Di;
            ai_p <= ai_q;
            ci_p <= ci_q;
            di_p <= di_q;
        end
    end

    // Legal selection: exactly one anode low. Idle and multi-select both fall
    // into the default arm.
    logic       legal;
    digit_idx_t idx;

    always_comb begin
        legal = 1'b1;
        idx   = 2'd0;
        case (ai_q)
            AN_DIG0: idx = 2'd0;
            AN_DIG1: idx = 2'd1;
            AN_DIG2: idx = 2'd2;
            AN_DIG3: idx = 2'd3;
            default: legal = 1'b0;
        endcase
    end

    // Stability counter: reloads to 1 on a new sample, saturates at
    // STABLE_MAX, and is held at 0 while the selection is not legal.
    logic       same;
    logic [3:0] stab_cnt, stab_next;
    logic       commit;

    assign same = ({ai_q, ci_q, di_q} == {ai_p, ci_p, di_p});

    always_comb begin
        stab_next = 4'd0;
        if (legal) begin
            if (!same)
                stab_next = 4'd1;
            else if (stab_cnt < STABLE_MAX)
                stab_next = stab_cnt + 4'd1;
            else
                stab_next = stab_cnt;
        end
    end

    // Commit only on the transition into STABLE_MAX; a new sample counts as
    // a transition so STABLE_CNT=1 still commits once per dwell.
    assign commit = legal && (stab_next == STABLE_MAX) &&
                    (!same || (stab_cnt != STABLE_MAX));

    logic [3:0] dec_nibble;
    logic       dec_blank;
    logic       dec_err;

    seg7_decode u_decode (
        .seg    (ci_q),
        .nibble (dec_nibble),
        .blank  (dec_blank),
        .err    (dec_err)
    );

    // Timeout fires once, on the edge the idle count reaches TIMEOUT; a commit
    // on that same edge takes priority.
    logic [15:0] tmo_cnt;
    logic        timeout;

    assign timeout = !commit && (tmo_cnt == TIMEOUT_LAST);

    logic [3:0] seen, seen_with;
    logic       frame_hit;

    assign seen_with = seen | (commit ? digit_onehot(idx) : 4'h0);
    assign frame_hit = commit && (seen_with == 4'hF);

    logic [3:0][3:0] bcd_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stab_cnt   <= 4'd0;
            tmo_cnt    <= 16'd0;
            seen       <= 4'h0;
            // NOTE: bcd_r is a four-entry register bank, not a RAM, so it is
            // reset with the rest of the state.
            bcd_r      <= '0;
            dp         <= 4'h0;
            dig_valid  <= 4'h0;
            dig_blank  <= 4'h0;
            dig_err    <= 4'h0;
            frame_done <= 1'b0;
        end else begin
            stab_cnt   <= stab_next;
            frame_done <= frame_hit;

            if (commit)
                tmo_cnt <= 16'd0;
            else if (tmo_cnt != TIMEOUT_MAX)
                tmo_cnt <= tmo_cnt + 16'd1;

            if (frame_hit || timeout)
                seen <= 4'h0;
            else
                seen <= seen_with;

            if (commit) begin
                dp[idx]        <= ~di_q;
                dig_valid[idx] <= ~(dec_blank | dec_err);
                dig_blank[idx] <= dec_blank;
                dig_err[idx]   <= dec_err;
                if (!dec_blank && !dec_err)
                    bcd_r[idx] <= dec_nibble;
            end else if (timeout) begin
                dig_valid <= 4'h0;
                dig_blank <= 4'h0;
                dig_err   <= 4'h0;
            end
        end
    end

    assign bcd0 = bcd_r[0];
    assign bcd1 = bcd_r[1];
    assign bcd2 = bcd_r[2];
    assign bcd3 = bcd_r[3];

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// -----------------------------------------------------------------------------
// tb_seg7_scan_decoder
//   Directed scenarios followed by randomized pin activity. A pin-history
//   model (run length of identical samples) predicts every output each cycle.
// -----------------------------------------------------------------------------
module tb_seg7_scan_decoder;

    localparam int S = 2;
    localparam int T = 64;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] Ai    = 4'hF;
    logic [6:0] Ci    = 7'h7F;
    logic       Di    = 1'b1;
    logic [3:0] bcd0, bcd1, bcd2, bcd3;
    logic [3:0] dp, dig_valid, dig_blank, dig_err;
    logic       frame_done;

    seg7_scan_decoder #(.STABLE_CNT(S), .TIMEOUT(T)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .Ai         (Ai),
        .Ci         (Ci),
        .Di         (Di),
        .bcd0       (bcd0),
        .bcd1       (bcd1),
        .bcd2       (bcd2),
        .bcd3       (bcd3),
        .dp         (dp),
        .dig_valid  (dig_valid),
        .dig_blank  (dig_blank),
        .dig_err    (dig_err),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int frames   = 0;
    bit chk_en   = 1'b0;

    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    logic [3:0] an_tab [4] = '{4'hE, 4'hD, 4'hB, 4'h7};

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [11:0] m_last;
    int          m_run;
    int          m_idle;
    logic [3:0]  m_bcd [4];
    logic [3:0]  m_dp, m_valid, m_blank, m_err, m_seen;
    logic        m_frame;

    task automatic model_reset();
        m_last  = {4'hF, 7'h7F, 1'b1};
        m_run   = 0;
        m_idle  = 0;
        for (int k = 0; k < 4; k++) m_bcd[k] = 4'h0;
        m_dp    = 4'h0;
        m_valid = 4'h0;
        m_blank = 4'h0;
        m_err   = 4'h0;
        m_seen  = 4'h0;
        m_frame = 1'b0;
    endtask

    // One clock edge: a commit happens when the run of identical samples that
    // ended on the previous edge is a legal selection exactly S samples long.
    task automatic model_step(input logic [11:0] pins);
        logic [3:0] low;
        int         d;
        int         code;
        bit         commit;
        low     = ~m_last[11:8];
        commit  = ($countones(low) == 1) && (m_run == S);
        m_frame = 1'b0;
        if (commit) begin
            d = 0;
            for (int k = 0; k < 4; k++) if (low[k]) d = k;
            code = -1;
            for (int k = 0; k < 16; k++) if (seg_tab[k] == m_last[7:1]) code = k;
            m_dp[d]    = ~m_last[0];
            m_valid[d] = 1'b0;
            m_blank[d] = 1'b0;
            m_err[d]   = 1'b0;
            if (m_last[7:1] == 7'h7F) m_blank[d] = 1'b1;
            else if (code >= 0) begin
                m_valid[d] = 1'b1;
                m_bcd[d]   = 4'(code);
            end else m_err[d] = 1'b1;
            m_seen[d] = 1'b1;
            if (m_seen == 4'hF) begin
                m_frame = 1'b1;
                m_seen  = 4'h0;
            end
            m_idle = 0;
        end else begin
            m_idle++;
            if (m_idle == T) begin
                m_valid = 4'h0;
                m_blank = 4'h0;
                m_err   = 4'h0;
                m_seen  = 4'h0;
            end
        end
        if (pins == m_last) begin
            if (m_run < 1000) m_run++;
        end else begin
            m_last = pins;
            m_run  = 1;
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else        model_step({Ai, Ci, Di});
    end

    // ---------------- per-cycle comparison ----------------
    always @(negedge clk) begin
        if (frame_done === 1'b1) frames++;
        if (chk_en) begin
            check("bcd0",       16'(bcd0),       16'(m_bcd[0]));
            check("bcd1",       16'(bcd1),       16'(m_bcd[1]));
            check("bcd2",       16'(bcd2),       16'(m_bcd[2]));
            check("bcd3",       16'(bcd3),       16'(m_bcd[3]));
            check("dp",         16'(dp),         16'(m_dp));
            check("dig_valid",  16'(dig_valid),  16'(m_valid));
            check("dig_blank",  16'(dig_blank),  16'(m_blank));
            check("dig_err",    16'(dig_err),    16'(m_err));
            check("frame_done", 16'(frame_done), 16'(m_frame));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic drive(input logic [3:0] a, input logic [6:0] c, input logic d, input int n);
        Ai = a;
        Ci = c;
        Di = d;
        tick(n);
    endtask

    task automatic scan(input int v0, input int v1, input int v2, input int v3);
        drive(4'hE, seg_tab[v0], 1'b1, 4);
        drive(4'hD, seg_tab[v1], 1'b1, 4);
        drive(4'hB, seg_tab[v2], 1'b1, 4);
        drive(4'h7, seg_tab[v3], 1'b1, 4);
    endtask

    int         f0;
    int         kind;
    int         r;
    int         n;
    logic [3:0] ra;
    logic [6:0] rc;

    initial begin
        rst_n = 1'b0;
        tick(3);
        chk_en = 1'b1;
        tick(1);
        check("reset bcd",   {bcd3, bcd2, bcd1, bcd0}, 16'h0000);
        check("reset flags", {dp, dig_valid, dig_blank, dig_err}, 16'h0000);
        check("reset frame", 16'(frame_done), 16'h0);

        rst_n = 1'b1;
        tick(2);

        // Single-cycle selection must not commit.
        drive(4'hE, seg_tab[1], 1'b1, 1);
        drive(4'hD, seg_tab[1], 1'b1, 4);
        check("short dwell valid", 16'(dig_valid), 16'h2);
        check("short dwell bcd1",  16'(bcd1),      16'h1);
        drive(4'hF, 7'h7F, 1'b1, 2);

        // Two full scans of 3,1,4,1: one frame pulse each.
        f0 = frames;
        scan(1, 4, 1, 3);
        check("scan1 frames", 16'(frames - f0), 16'd1);
        f0 = frames;
        scan(1, 4, 1, 3);
        check("scan2 frames", 16'(frames - f0), 16'd1);
        check("scan bcd",   {bcd3, bcd2, bcd1, bcd0}, 16'h3141);
        check("scan valid", 16'(dig_valid), 16'hF);
        check("model scan bcd", {m_bcd[3], m_bcd[2], m_bcd[1], m_bcd[0]}, 16'h3141);
        check("model scan valid", 16'(m_valid), 16'hF);

        // Illegal multi-select must change nothing.
        f0 = frames;
        drive(4'hC, seg_tab[8], 1'b1, 10);
        check("illegal frames", 16'(frames - f0), 16'd0);
        check("illegal bcd",    {bcd3, bcd2, bcd1, bcd0}, 16'h3141);
        check("illegal valid",  16'(dig_valid), 16'hF);

        // Blank then undecodable on digit 2; bcd2 holds.
        drive(4'hB, 7'h7F, 1'b1, 4);
        check("blank2 flags", 16'({dig_valid[2], dig_blank[2], dig_err[2]}), 16'b010);
        check("blank2 bcd",   16'(bcd2), 16'h1);
        drive(4'hB, 7'b0110110, 1'b1, 4);
        check("err2 flags", 16'({dig_valid[2], dig_blank[2], dig_err[2]}), 16'b001);
        check("err2 bcd",   16'(bcd2), 16'h1);
        check("model err2", 16'({m_valid[2], m_blank[2], m_err[2]}), 16'b001);

        // Timeout: last commit lands on the third edge of the digit-3 dwell.
        scan(1, 4, 1, 3);
        drive(4'hF, 7'h7F, 1'b1, T - 2);
        check("pre-timeout valid", 16'(dig_valid), 16'hF);
        tick(1);
        check("timeout flags", {4'h0, dig_valid, dig_blank, dig_err}, 16'h0000);
        check("timeout bcd",   {bcd3, bcd2, bcd1, bcd0}, 16'h3141);
        check("model timeout valid", 16'(m_valid), 16'h0);

        // Reset in the middle of a digit-1 dwell with the decimal point on.
        drive(4'hD, seg_tab[5], 1'b0, 1);
        rst_n = 1'b0;
        tick(1);
        check("midrst bcd",   {bcd3, bcd2, bcd1, bcd0}, 16'h0000);
        check("midrst flags", {dp, dig_valid, dig_blank, dig_err}, 16'h0000);
        check("midrst frame", 16'(frame_done), 16'h0);
        rst_n = 1'b1;
        tick(1);
        check("post-rst dp e1", 16'(dp), 16'h0);
        tick(1);
        check("post-rst dp e2", 16'(dp), 16'h0);
        tick(1);
        check("post-rst dp e3",   16'(dp), 16'h2);
        check("post-rst bcd1",    16'(bcd1), 16'h5);
        check("post-rst valid",   16'(dig_valid), 16'h2);

        // Randomized pin activity against the model.
        for (int i = 0; i < 600; i++) begin
            kind = $urandom_range(99);
            if (kind < 3) begin
                rst_n = 1'b0;
                tick(1 + $urandom_range(2));
                rst_n = 1'b1;
            end
            r = $urandom_range(9);
            if (r < 7)       ra = an_tab[$urandom_range(3)];
            else if (r == 7) ra = 4'hF;
            else if (r == 8) ra = 4'($urandom_range(15));
            else             ra = an_tab[$urandom_range(3)];
            r = $urandom_range(15);
            if (r < 12)       rc = seg_tab[$urandom_range(15)];
            else if (r == 12) rc = 7'h7F;
            else              rc = 7'($urandom_range(127));
            n = (kind >= 97) ? (T + $urandom_range(10)) : (1 + $urandom_range(4));
            drive(ra, rc, 1'($urandom_range(1)), n);
        end

        tick(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
